tx_arbiter: RTL and testbench

- Shares the single serial TX channel between the instruction scheduler and the prefetch unit.
- Arbitrates command starts, honours the scheduler's TX reservation and serializes header plus payload NSHIFT bits per cycle.
- Records the owner of every outstanding read in a small FIFO, so that incoming RX replies are routed to the scheduler, routed to prefetch, or dropped.
- Sits between scheduler/prefetch and the TX/RX pin logic.

---
 rtl/tx_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Shares one serial TX channel between scheduler and prefetch; tracks reply owners.
// Optional round-robin tie-break between requesters: define TX_ROUND_ROBIN_EN.
module tx_arbiter #(
    parameter int NSHIFT          = 2,
    parameter int PAYLOAD_CYCLES  = 8,
    parameter int CMD_BITS        = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int PF_CMD          = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  sched_cmd_valid,
    input  logic [CMD_BITS-1:0]                   sched_cmd,
    input  logic                                  sched_is_read,
    input  logic                                  sched_reply_wanted,
    input  logic                                  sched_reserve,
    input  logic [NSHIFT-1:0]                     sched_data,
    output logic                                  sched_started,
    output logic                                  sched_data_next,
    input  logic                                  pf_cmd_valid,
    input  logic [NSHIFT-1:0]                     pf_data,
    output logic                                  pf_started,
    output logic                                  pf_data_next,
    output logic [NSHIFT-1:0]                     tx_pins,
    output logic                                  tx_active,
    output logic                                  tx_owner,
    output logic [$clog2(PAYLOAD_CYCLES):0]       tx_counter,
    output logic                                  tx_done,
    input  logic                                  rx_done,
    output logic                                  rx_owner_valid,
    output logic                                  rx_owner,
    output logic                                  rx_discard,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding
);

    localparam int HEADER_CYCLES = CMD_BITS / NSHIFT;
    localparam int IW = $clog2(PAYLOAD_CYCLES);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int OW = PW + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEADER  = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;

    localparam logic [IW-1:0] LAST_HDR = IW'(HEADER_CYCLES - 1);
    localparam logic [IW-1:0] LAST_PAY = IW'(PAYLOAD_CYCLES - 1);
    localparam logic [CMD_BITS-1:0] PF_HDR = CMD_BITS'(PF_CMD);
    localparam logic [OW-1:0] FIFO_DEPTH = OW'(MAX_OUTSTANDING);

    logic [1:0]          state;
    logic [IW-1:0]       cnt;
    logic                owner_q;
    logic [CMD_BITS-1:0] hdr_q;

    logic                owner_mem [MAX_OUTSTANDING];
    logic                disc_mem  [MAX_OUTSTANDING];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [OW-1:0]       count;

    logic fifo_full;
    logic fifo_empty;
    logic s_elig;
    logic p_elig;
    logic pick_s;
    logic pick_p;
    logic grant_s;
    logic grant_p;
    logic push;
    logic pop;

    assign fifo_full  = (count == FIFO_DEPTH);
    assign fifo_empty = (count == '0);

    assign s_elig = sched_cmd_valid && !(sched_is_read && fifo_full);
    assign p_elig = pf_cmd_valid && !sched_reserve && !fifo_full;

`ifdef TX_ROUND_ROBIN_EN
    // 1 = scheduler took the most recent grant
    logic last_owner;

    assign pick_s = s_elig && (!p_elig || !last_owner);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= 1'b0;
        end else if (grant_s || grant_p) begin
            last_owner <= grant_s;
        end
    end
`else
    assign pick_s = s_elig;
`endif

    assign pick_p  = p_elig && !pick_s;
    assign grant_s = !reset && (state == IDLE) && pick_s;
    assign grant_p = !reset && (state == IDLE) && pick_p;

    assign sched_started = grant_s;
    assign pf_started    = grant_p;

    assign push = (grant_s && sched_is_read) || grant_p;
    assign pop  = rx_done && !fifo_empty && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            owner_q <= 1'b0;
            hdr_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_s || grant_p) begin
                        state   <= HEADER;
                        cnt     <= '0;
                        owner_q <= grant_s;
                        hdr_q   <= grant_s ? sched_cmd : PF_HDR;
                    end
                end
                HEADER: begin
                    hdr_q <= hdr_q << NSHIFT;
                    if (cnt == LAST_HDR) begin
                        state <= PAYLOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + IW'(1);
                    end
                end
                PAYLOAD: begin
                    if (cnt == LAST_PAY) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        tx_pins         = '0;
        tx_active       = 1'b0;
        tx_owner        = 1'b0;
        tx_counter      = '0;
        tx_done         = 1'b0;
        sched_data_next = 1'b0;
        pf_data_next    = 1'b0;
        if (!reset) begin
            unique case (state)
                HEADER: begin
                    tx_active  = 1'b1;
                    tx_owner   = owner_q;
                    tx_pins    = hdr_q[CMD_BITS-1 -: NSHIFT];
                    tx_counter = {1'b0, cnt};
                end
                PAYLOAD: begin
                    tx_active       = 1'b1;
                    tx_owner        = owner_q;
                    tx_pins         = owner_q ? sched_data : pf_data;
                    sched_data_next = owner_q;
                    pf_data_next    = !owner_q;
                    tx_counter      = {1'b1, cnt};
                    tx_done         = (cnt == LAST_PAY);
                end
                default: ;
            endcase
        end
    end

    // Written at grant, read next cycle, so push+pop at occupancy 1 sees the new head
    always_ff @(posedge clk) begin
        if (push) begin
            owner_mem[wr_ptr] <= grant_s;
            disc_mem[wr_ptr]  <= grant_s && !sched_reply_wanted;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rx_owner_valid = !reset && !fifo_empty;
    assign rx_owner       = rx_owner_valid && owner_mem[rd_ptr];
    assign rx_discard     = rx_owner_valid && disc_mem[rd_ptr];
    assign outstanding    = reset ? '0 : count;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios then random traffic vs a queue-based model.
// Build with TX_ROUND_ROBIN_EN defined to exercise the alternating tie-break.
module tb_tx_arbiter;

    localparam int NS  = 2;
    localparam int PC  = 8;
    localparam int CB  = 2;
    localparam int MO  = 2;
    localparam int PFC = 0;
    localparam int HC  = CB / NS;
    localparam int IW  = $clog2(PC);

    logic          clk = 1'b0;
    logic          reset;
    logic          sched_cmd_valid;
    logic [CB-1:0] sched_cmd;
    logic          sched_is_read;
    logic          sched_reply_wanted;
    logic          sched_reserve;
    logic [NS-1:0] sched_data;
    logic          sched_started;
    logic          sched_data_next;
    logic          pf_cmd_valid;
    logic [NS-1:0] pf_data;
    logic          pf_started;
    logic          pf_data_next;
    logic [NS-1:0] tx_pins;
    logic          tx_active;
    logic          tx_owner;
    logic [IW:0]   tx_counter;
    logic          tx_done;
    logic          rx_done;
    logic          rx_owner_valid;
    logic          rx_owner;
    logic          rx_discard;
    logic [$clog2(MO):0] outstanding;

    tx_arbiter #(
        .NSHIFT(NS), .PAYLOAD_CYCLES(PC), .CMD_BITS(CB),
        .MAX_OUTSTANDING(MO), .PF_CMD(PFC)
    ) dut (
        .clk(clk), .reset(reset),
        .sched_cmd_valid(sched_cmd_valid), .sched_cmd(sched_cmd),
        .sched_is_read(sched_is_read), .sched_reply_wanted(sched_reply_wanted),
        .sched_reserve(sched_reserve), .sched_data(sched_data),
        .sched_started(sched_started), .sched_data_next(sched_data_next),
        .pf_cmd_valid(pf_cmd_valid), .pf_data(pf_data),
        .pf_started(pf_started), .pf_data_next(pf_data_next),
        .tx_pins(tx_pins), .tx_active(tx_active), .tx_owner(tx_owner),
        .tx_counter(tx_counter), .tx_done(tx_done),
        .rx_done(rx_done), .rx_owner_valid(rx_owner_valid),
        .rx_owner(rx_owner), .rx_discard(rx_discard),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: position within the transaction (0 = idle,
    // 1..HC header, HC+1..HC+PC payload) plus a queue of {owner, discard}.
    int       pos  = 0;
    bit       own  = 1'b0;
    int       hdr  = 0;
    bit       last = 1'b0;
    bit [1:0] q[$];
    bit       gs;
    bit       gp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        int e_pins = 0, e_act = 0, e_own = 0, e_cnt = 0, e_done = 0;
        int e_sn = 0, e_pn = 0, e_v = 0, e_ro = 0, e_rd = 0, e_out = 0;
        int k;
        bit se, pe;
        gs = 1'b0;
        gp = 1'b0;
        if (!reset) begin
            if (pos == 0) begin
                se = sched_cmd_valid && !(sched_is_read && q.size() == MO);
                pe = pf_cmd_valid && !sched_reserve && q.size() < MO;
`ifdef TX_ROUND_ROBIN_EN
                gs = se && (!pe || !last);
`else
                gs = se;
`endif
                gp = pe && !gs;
            end else if (pos <= HC) begin
                e_act  = 1;
                e_own  = own;
                e_pins = (hdr >> (CB - NS * pos)) & ((1 << NS) - 1);
                e_cnt  = pos - 1;
            end else begin
                k      = pos - HC - 1;
                e_act  = 1;
                e_own  = own;
                e_pins = own ? int'(sched_data) : int'(pf_data);
                e_sn   = own;
                e_pn   = !own;
                e_cnt  = (1 << IW) + k;
                e_done = (k == PC - 1);
            end
            e_v   = (q.size() > 0);
            e_ro  = e_v ? q[0][1] : 0;
            e_rd  = e_v ? q[0][0] : 0;
            e_out = q.size();
        end
        #4;
        chk("sched_started", sched_started, gs);
        chk("pf_started", pf_started, gp);
        chk("tx_pins", tx_pins, e_pins);
        chk("tx_active", tx_active, e_act);
        chk("tx_owner", tx_owner, e_own);
        chk("tx_counter", tx_counter, e_cnt);
        chk("tx_done", tx_done, e_done);
        chk("sched_data_next", sched_data_next, e_sn);
        chk("pf_data_next", pf_data_next, e_pn);
        chk("rx_owner_valid", rx_owner_valid, e_v);
        chk("rx_owner", rx_owner, e_ro);
        chk("rx_discard", rx_discard, e_rd);
        chk("outstanding", outstanding, e_out);
        @(posedge clk);
        if (reset) begin
            pos  = 0;
            last = 1'b0;
            q.delete();
        end else begin
            if (rx_done && q.size() > 0) void'(q.pop_front());
            if (gs && sched_is_read) q.push_back({1'b1, !sched_reply_wanted});
            if (gp) q.push_back(2'b00);
            if (gs || gp) begin
                pos  = 1;
                own  = gs;
                hdr  = gs ? int'(sched_cmd) : PFC;
                last = gs;
            end else if (pos > 0) begin
                pos = (pos == HC + PC) ? 0 : pos + 1;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Step until the model grants the named requester; returns cycles taken
    task automatic wg(input bit s, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(s ? gs : gp) && n < 40);
        if (!(s ? gs : gp)) begin
            total++;
            $error("FAIL grant_timeout observed=none expected=%s", s ? "sched" : "pf");
        end
        if (s) sched_cmd_valid = 1'b0;
        else pf_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        rx_done = 1'b1;
        run(MO + 1);
        rx_done = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        sched_cmd_valid = 0; sched_cmd = 0; sched_is_read = 0;
        sched_reply_wanted = 1; sched_reserve = 0; sched_data = 0;
        pf_cmd_valid = 0; pf_data = 0; rx_done = 0;
        @(posedge clk);
        #1;
        run(2);
        reset = 1'b0;
        run(1);

        // prefetch alone
        pf_data = 2'b10;
        pf_cmd_valid = 1'b1;
        wg(1'b0, n);
        run(HC + PC);
        chk("pf_outstanding", outstanding, 1);
        drain();

        // simultaneous requests: scheduler first, prefetch right after tx_done
        sched_cmd = 2'b11; sched_is_read = 0; sched_data = 2'b01;
        sched_cmd_valid = 1; pf_cmd_valid = 1;
        wg(1'b1, n);
        wg(1'b0, n);
        chk("pf_after_done", n, HC + PC + 1);
        run(HC + PC);
        drain();

        // repeated contention: alternates under round robin
        for (int i = 0; i < 4; i++) begin
            sched_cmd_valid = 1; pf_cmd_valid = 1;
            n = 0;
            do begin step(); n++; end while (!(gs || gp) && n < 40);
            if (gs) sched_cmd_valid = 0;
            if (gp) pf_cmd_valid = 0;
        end
        sched_cmd_valid = 0; pf_cmd_valid = 0;
        run(2 * (HC + PC + 1));
        drain();

        // reservation blocks prefetch
        sched_reserve = 1; pf_cmd_valid = 1;
        run(20);
        sched_reserve = 0;
        wg(1'b0, n);
        chk("reserve_release", n, 1);
        run(HC + PC);
        drain();

        // FIFO full holds off prefetch
        pf_cmd_valid = 1; wg(1'b0, n); run(HC + PC);
        pf_cmd_valid = 1; wg(1'b0, n); run(HC + PC);
        chk("fifo_full", outstanding, 2);
        pf_cmd_valid = 1;
        run(15);
        pf_cmd_valid = 0;
        rx_done = 1; run(1); rx_done = 0;
        chk("after_pop", outstanding, 1);

        // push and pop together at occupancy 1; discarded scheduler read
        sched_cmd = 2'b01; sched_is_read = 1; sched_reply_wanted = 0;
        sched_cmd_valid = 1; rx_done = 1;
        wg(1'b1, n);
        rx_done = 0;
        chk("pushpop_occ", outstanding, 1);
        chk("disc_owner", rx_owner, 1);
        chk("disc_flag", rx_discard, 1);
        run(HC + PC);
        sched_is_read = 0; sched_reply_wanted = 1; sched_cmd_valid = 1;
        wg(1'b1, n);
        run(HC + PC);
        chk("write_no_push", outstanding, 1);
        drain();

        // reset mid-payload
        pf_cmd_valid = 1;
        wg(1'b0, n);
        run(HC + 3);
        reset = 1;
        step();
        reset = 0;
        chk("rst_active", tx_active, 0);
        chk("rst_outstanding", outstanding, 0);
        step();
        pf_cmd_valid = 1;
        wg(1'b0, n);
        run(HC + PC);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if (!sched_cmd_valid && $urandom_range(3) == 0) begin
                sched_cmd_valid    = 1;
                sched_cmd          = CB'($urandom);
                sched_is_read      = 1'($urandom);
                sched_reply_wanted = 1'($urandom);
            end
            if (!pf_cmd_valid && $urandom_range(2) == 0) pf_cmd_valid = 1;
            sched_reserve = ($urandom_range(4) == 0);
            rx_done       = ($urandom_range(5) == 0);
            sched_data    = NS'($urandom);
            pf_data       = NS'($urandom);
            reset         = ($urandom_range(150) == 0);
            step();
            if (gs || reset) sched_cmd_valid = 0;
            if (gp || reset) pf_cmd_valid = 0;
        end
        reset = 0; rx_done = 0;
        sched_cmd_valid = 0; pf_cmd_valid = 0;
        run(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
